// File: rtl/ws2812b_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ws2812b_rx_decoder
// Description : Decodes a WS2812B single-wire NRZ stream into 24-bit GRB words
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812b_rx_decoder #(
    parameter int BIT_THRESH   = 6,
    parameter int MIN_HIGH     = 2,
    parameter int MAX_HIGH     = 11,
    parameter int RESET_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic [7:0]  pixel_index,
    output logic        frame_done,
    output logic        bit_error,
    output logic        busy
);
    localparam int C_HW = $clog2(MAX_HIGH + 2);
    localparam int C_LW = $clog2(RESET_CYCLES + 1);
    localparam logic [C_HW-1:0] C_HIGH_MIN = C_HW'(MIN_HIGH);
    localparam logic [C_HW-1:0] C_HIGH_THR = C_HW'(BIT_THRESH);
    localparam logic [C_HW-1:0] C_HIGH_MAX = C_HW'(MAX_HIGH);
    localparam logic [C_HW-1:0] C_HIGH_SAT = C_HW'(MAX_HIGH + 1);
    localparam logic [C_LW-1:0] C_LOW_LAST = C_LW'(RESET_CYCLES - 1);
    localparam logic [C_LW-1:0] C_LOW_SAT  = C_LW'(RESET_CYCLES);

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_din_d;
    logic              r_rise;
    logic              r_fall;
    logic [C_HW-1:0]   r_high_cnt;
    logic [C_LW-1:0]   r_low_cnt;
    logic [4:0]        r_bit_cnt;
    logic [22:0]       r_shift;
    logic [7:0]        r_pix_cnt;
    logic              r_wrapped;
    logic [23:0]       r_pixel_data;
    logic              r_pixel_valid;
    logic [7:0]        r_pixel_index;
    logic              r_frame_done;
    logic              r_bit_error;
    logic              r_busy;

    logic              w_bit;
    logic [23:0]       w_shift_next;

    // Only 23 bits are stored: the 24th goes straight into pixel_data.
    assign w_bit        = (r_high_cnt >= C_HIGH_THR);
    assign w_shift_next = {r_shift, w_bit};

    assign pixel_data  = r_pixel_data;
    assign pixel_valid = r_pixel_valid;
    assign pixel_index = r_pixel_index;
    assign frame_done  = r_frame_done;
    assign bit_error   = r_bit_error;
    assign busy        = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ARM;
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_din_d       <= 1'b0;
            r_rise        <= 1'b0;
            r_fall        <= 1'b0;
            r_high_cnt    <= '0;
            r_low_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_pix_cnt     <= '0;
            r_wrapped     <= 1'b0;
            r_pixel_data  <= '0;
            r_pixel_valid <= 1'b0;
            r_pixel_index <= '0;
            r_frame_done  <= 1'b0;
            r_bit_error   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_sync1       <= din;
            r_sync2       <= r_sync1;
            r_din_d       <= r_sync2;
            r_rise        <= r_sync2 & ~r_din_d;
            r_fall        <= ~r_sync2 & r_din_d;
            r_pixel_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            r_bit_error   <= 1'b0;

            case (r_state)
                ARM: begin
                    // Any high restarts the gap count so we only lock at a frame start.
                    if (r_din_d) begin
                        r_low_cnt <= '0;
                    end else if (r_low_cnt == C_LOW_LAST) begin
                        r_low_cnt <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_low_cnt <= r_low_cnt + 1'b1;
                    end
                end

                IDLE: begin
                    if (r_rise) begin
                        r_high_cnt <= C_HW'(1);
                        r_busy     <= 1'b1;
                        r_state    <= HIGH;
                    end
                end

                HIGH: begin
                    if (r_fall && (r_high_cnt < C_HIGH_MIN)) begin
                        r_bit_error   <= 1'b1;
                        r_shift       <= '0;
                        r_bit_cnt     <= '0;
                        r_pix_cnt     <= '0;
                        r_wrapped     <= 1'b0;
                        r_pixel_index <= '0;
                        r_busy        <= 1'b0;
                        r_low_cnt     <= '0;
                        r_state       <= ARM;
                    end else if (r_fall) begin
                        r_low_cnt <= C_LW'(1);
                        r_state   <= LOW;
                        if (r_bit_cnt == 5'd23) begin
                            r_pixel_data  <= w_shift_next;
                            r_pixel_valid <= 1'b1;
                            r_pixel_index <= r_pix_cnt;
                            r_pix_cnt     <= r_pix_cnt + 8'd1;
                            if (r_pix_cnt == 8'hFF) begin
                                r_wrapped <= 1'b1;
                            end
                            r_bit_cnt     <= '0;
                            r_shift       <= '0;
                        end else begin
                            r_shift   <= w_shift_next[22:0];
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end else if (r_high_cnt >= C_HIGH_MAX) begin
                        r_high_cnt    <= C_HIGH_SAT;
                        r_bit_error   <= 1'b1;
                        r_shift       <= '0;
                        r_bit_cnt     <= '0;
                        r_pix_cnt     <= '0;
                        r_wrapped     <= 1'b0;
                        r_pixel_index <= '0;
                        r_busy        <= 1'b0;
                        r_low_cnt     <= '0;
                        r_state       <= ARM;
                    end else begin
                        r_high_cnt <= r_high_cnt + 1'b1;
                    end
                end

                LOW: begin
                    if (r_rise) begin
                        r_high_cnt <= C_HW'(1);
                        r_state    <= HIGH;
                    end else if (r_low_cnt == C_LOW_LAST) begin
                        r_low_cnt     <= C_LOW_SAT;
                        r_frame_done  <= (r_bit_cnt == 5'd0) && ((r_pix_cnt != 8'd0) || r_wrapped);
                        r_bit_error   <= (r_bit_cnt != 5'd0);
                        r_shift       <= '0;
                        r_bit_cnt     <= '0;
                        r_pix_cnt     <= '0;
                        r_wrapped     <= 1'b0;
                        r_pixel_index <= '0;
                        r_busy        <= 1'b0;
                        r_state       <= IDLE;
                    end else begin
                        r_low_cnt <= r_low_cnt + 1'b1;
                    end
                end

                default: r_state <= ARM;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: doc/ws2812b_rx_decoder.md
Name: ws2812b_rx_decoder

Overview:
- Receive-side counterpart of the project's WS2812B driver: decodes the single-wire NRZ pulse stream back into 24-bit GRB pixel words.
- Used as an on-chip loopback checker on the LED data output, and as an input decoder when the design is chained behind another WS2812B source.
- Measures the high time of each bit against a cycle threshold, assembles pixels MSB-first, counts pixels and detects the latch/reset gap.

Parameters:
- BIT_THRESH, 6, high time in clk cycles at or above which a bit decodes as 1 (0.6 us at 10 MHz)
- MIN_HIGH, 2, shortest legal high pulse in cycles; shorter is a glitch error
- MAX_HIGH, 11, longest legal high pulse in cycles; longer is an error
- RESET_CYCLES, 500, continuous low cycles that mark frame end/latch (50 us at 10 MHz)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- din  in  1  asynchronous WS2812B serial input
- pixel_data  out  24  last complete pixel, {G[7:0],R[7:0],B[7:0]} in received order
- pixel_valid  out  1  one-cycle strobe, pixel_data/pixel_index valid
- pixel_index  out  8  index of the pixel in pixel_data within the current frame
- frame_done  out  1  one-cycle strobe on reset-gap detection after at least one full pixel
- bit_error  out  1  one-cycle strobe on protocol violation
- busy  out  1  high while a frame is in progress (from first rising edge until frame end/error)

Behaviour:
- Reset: all outputs 0, shift register and all counters 0, FSM in ARM.
- Interface decided: one clock clk; reset rst_n is asynchronous and active-low.
- din passes a 2-flop synchronizer, then a registered copy for edge detection; rise/fall are detected on the synchronized signal.
- FSM states: ARM, IDLE, HIGH, LOW.
- ARM: low_cnt counts consecutive low cycles and restarts on any high. At RESET_CYCLES, go to IDLE. Edges are ignored in ARM, so the decoder never locks onto a frame mid-stream.
- IDLE: a rise edge goes to HIGH with high_cnt=1 and busy=1.
- HIGH: high_cnt increments, saturating at MAX_HIGH+1.
  - Fall with high_cnt<MIN_HIGH, or high_cnt reaching MAX_HIGH+1 while still high: bit_error pulse, discard the partial pixel, clear pixel_index, busy=0, go to ARM.
  - Legal fall: bit = (high_cnt>=BIT_THRESH). Shift it into the LSB (so the first bit ends up in pixel_data bit 23). bit_cnt++, low_cnt=1, go to LOW.
  - When bit_cnt reaches 24: load pixel_data, pulse pixel_valid, output the current pixel_index, then pixel_index++ (wraps 255->0) and bit_cnt=0.
- LOW: low_cnt increments, saturating at RESET_CYCLES. A rise before RESET_CYCLES goes to HIGH with high_cnt=1. There is no minimum or maximum on low time short of the reset gap.
- LOW reaching RESET_CYCLES:
  - bit_cnt==0: pulse frame_done (only if pixel_index!=0 or a pixel wrapped).
  - bit_cnt!=0: pulse bit_error and discard the partial pixel.
  - Either case: clear pixel_index, busy=0, go to IDLE.
- Latency: pixel_valid is high in the 4th cycle after the clk edge that first samples din low at the 24th falling edge (2 sync + 1 edge reg + 1 output reg).
- pixel_data holds its value until the next completed pixel. pixel_valid, frame_done and bit_error are mutually exclusive in any cycle.
- Async reset mid-frame: immediate return to ARM, all outputs 0. The next frame is only decoded after a full RESET_CYCLES low gap.

Test Plan:
- Reset, din low 500 cycles, then one pixel 0xA5_0F_C3 (1 bits: 8 high/4 low, 0 bits: 4 high/8 low), then 500 low -> pixel_valid once with pixel_data=0xA50FC3, pixel_index=0, then frame_done once; bit_error never.
- Three back-to-back pixels 0xFF0000, 0x00FF00, 0x0000FF -> three pixel_valid strobes with indices 0, 1, 2; frame_done after the gap; pixel_index reads 0 on the next frame.
- Threshold edge: high of 5 cycles decodes 0, high of 6 decodes 1; 1-cycle high -> bit_error and ARM; 12-cycle high -> bit_error at cycle 12 while din still high.
- 12 bits then a 500-cycle low -> bit_error, no pixel_valid, no frame_done, busy=0.
- Stream started without a preceding gap (din toggling right after reset) -> no outputs until 500 low cycles are seen; the following frame decodes normally.
- Assert rst_n=0 mid-pixel for 1 cycle -> outputs 0 at once; no pixel_valid for the interrupted frame.
